iob_cache_front_end: RTL and testbench
======================================

IOB_CACHE_FRONT_END -- requirements
Module: iob_cache_front_end

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: IOB byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; NBYTES=DATA_W/8; NBYTES_W=log2(NBYTES).
REQ-003 SHALL have port clk_i, in, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_i, in, 1: reset, asynchronous and active-high.
REQ-005 SHALL have iob_avalid_i in 1, iob_addr_i in ADDR_W, iob_wdata_i in DATA_W, iob_wstrb_i in NBYTES: IOB request; write when wstrb!=0.
REQ-006 SHALL have iob_ready_o out 1, iob_rvalid_o out 1, iob_rdata_o out DATA_W: IOB response.
REQ-007 SHALL have data_req_o out 1, data_addr_o out ADDR_W-NBYTES_W, data_wdata_o out DATA_W, data_wstrb_o out NBYTES: cache-memory request.
REQ-008 SHALL have data_rdata_i in DATA_W, data_ack_i in 1: cache-memory response.
REQ-009 SHALL have ctrl_req_o out 1, ctrl_we_o out 1, ctrl_addr_o out 4, ctrl_wdata_o out DATA_W, ctrl_rdata_i in DATA_W: control-register port.

Function
REQ-010 SHALL implement FSM states IDLE, DATA_WAIT, CTRL_RESP.
REQ-011 SHALL accept a request in the cycle where iob_avalid_i=1 and iob_ready_o=1.
REQ-012 SHALL drive iob_ready_o=1 in IDLE, and in DATA_WAIT only in the cycle data_ack_i=1; 0 otherwise.
REQ-013 SHALL register address word bits, wdata, wstrb on acceptance; outputs stable until ack.
REQ-014 SHALL, on data-path acceptance, go to DATA_WAIT and assert data_req_o from the next cycle until the cycle data_ack_i=1 inclusive.
REQ-015 SHALL, in DATA_WAIT with data_ack_i=1, return to IDLE, or stay in DATA_WAIT loading the new request if one is accepted that cycle (back-to-back, no bubble on data_req_o).
REQ-016 SHALL, for a read acked at cycle N, assert iob_rvalid_o for exactly cycle N+1 with iob_rdata_o = data_rdata_i sampled at N.
REQ-017 SHALL NOT assert iob_rvalid_o for writes.
REQ-018 SHALL ignore data_ack_i outside DATA_WAIT.
REQ-019 SHALL hold iob_rdata_o at its last value when iob_rvalid_o=0.
REQ-020 SHALL ignore iob_avalid_i when iob_ready_o=0 (no queuing; master must hold request).

Reset
REQ-021 SHALL, on arst_i=1 at any time, go to IDLE immediately and drive iob_rvalid_o=0, iob_rdata_o=0, data_req_o=0, data_addr_o=0, data_wdata_o=0, data_wstrb_o=0, ctrl_req_o=0, ctrl_we_o=0, ctrl_addr_o=0, ctrl_wdata_o=0.
REQ-022 SHALL drop an in-flight request on reset; no rvalid afterwards for it.
REQ-023 SHALL drive iob_ready_o=1 from the first cycle after reset release.

Configuration
REQ-024 SHALL use macro IOB_CACHE_CTRL_IO_EN to compile in the control-register path.
REQ-025 With macro: accepted request with iob_addr_i[ADDR_W-1]=1 SHALL pulse ctrl_req_o one cycle, ctrl_we_o=(wstrb!=0), ctrl_addr_o=iob_addr_i[5:2], and enter CTRL_RESP; data_req_o stays 0.
REQ-026 With macro: CTRL_RESP SHALL last one cycle, iob_ready_o=0; reads assert iob_rvalid_o next cycle with ctrl_rdata_i sampled in CTRL_RESP; then IDLE.
REQ-027 Without macro: all requests SHALL use the data path including address MSB; ctrl_* outputs tied 0; CTRL_RESP unreachable.

Verification
REQ-028 Read addr 0x000010, ack 3 cycles later with rdata 0xDEADBEEF -> data_addr_o=0x4, rvalid one cycle after ack, rdata 0xDEADBEEF.
REQ-029 Write addr 0x20, wdata 0x12345678, wstrb 0xF, ack after 1 cycle -> data_wstrb_o=0xF, no rvalid, ready=1 in ack cycle.
REQ-030 Back-to-back reads 0x0,0x4, ack each after 2 cycles -> data_req_o continuous, two rvalid pulses in order.
REQ-031 arst_i pulse during DATA_WAIT -> data_req_o=0 immediately, no rvalid, ready=1 after release.
REQ-032 Macro on, read addr 0x800008 with ctrl_rdata_i=0x5 -> ctrl_req_o pulse, ctrl_addr_o=0x2, rvalid with 0x5, data_req_o never 1.
REQ-033 Spurious data_ack_i in IDLE -> no state change, no rvalid.

Source files
------------

// File: rtl/iob_cache_front_end.sv
// iob_cache_front_end: IOB slave front end driving the cache data port.
// Define IOB_CACHE_CTRL_IO_EN to route address-MSB requests to the control-register port.
module iob_cache_front_end #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                                     clk_i,
    input  logic                                     arst_i,
    input  logic                                     iob_avalid_i,
    input  logic [ADDR_W-1:0]                        iob_addr_i,
    input  logic [DATA_W-1:0]                        iob_wdata_i,
    input  logic [DATA_W/8-1:0]                      iob_wstrb_i,
    output logic                                     iob_ready_o,
    output logic                                     iob_rvalid_o,
    output logic [DATA_W-1:0]                        iob_rdata_o,
    output logic                                     data_req_o,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]       data_addr_o,
    output logic [DATA_W-1:0]                        data_wdata_o,
    output logic [DATA_W/8-1:0]                      data_wstrb_o,
    input  logic [DATA_W-1:0]                        data_rdata_i,
    input  logic                                     data_ack_i,
    output logic                                     ctrl_req_o,
    output logic                                     ctrl_we_o,
    output logic [3:0]                               ctrl_addr_o,
    output logic [DATA_W-1:0]                        ctrl_wdata_o,
    input  logic [DATA_W-1:0]                        ctrl_rdata_i
);
    localparam int NBYTES   = DATA_W / 8;
    localparam int NBYTES_W = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, DATA_WAIT, CTRL_RESP} state_t;

    state_t                     r_state, w_next;
    logic [ADDR_W-NBYTES_W-1:0] r_addr;
    logic [DATA_W-1:0]          r_wdata, r_rdata;
    logic [NBYTES-1:0]          r_wstrb;
    logic                       r_rvalid;
    logic                       w_accept, w_ctrl, w_data_ack, w_data_rd, w_ctrl_rd;
    logic [DATA_W-1:0]          w_ctrl_rdata;
    logic                       w_unused;

    assign w_data_ack   = (r_state == DATA_WAIT) & data_ack_i;
    assign w_data_rd    = w_data_ack & ~|r_wstrb;
    assign iob_ready_o  = (r_state == IDLE) | w_data_ack;
    assign w_accept     = iob_avalid_i & iob_ready_o;
    assign data_req_o   = r_state == DATA_WAIT;
    assign data_addr_o  = r_addr;
    assign data_wdata_o = r_wdata;
    assign data_wstrb_o = r_wstrb;
    assign iob_rvalid_o = r_rvalid;
    assign iob_rdata_o  = r_rdata;

    // a new acceptance always wins, which gives back-to-back data requests without a bubble
    always_comb begin
        w_next = !w_accept ? ((w_data_ack | (r_state == CTRL_RESP)) ? IDLE : r_state)
                           : (w_ctrl ? CTRL_RESP : DATA_WAIT);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= w_data_rd | w_ctrl_rd;
            if (w_data_rd)
                r_rdata <= data_rdata_i;
            else if (w_ctrl_rd)
                r_rdata <= w_ctrl_rdata;
            if (w_accept & ~w_ctrl) begin
                r_addr  <= iob_addr_i[ADDR_W-1:NBYTES_W];
                r_wdata <= iob_wdata_i;
                r_wstrb <= iob_wstrb_i;
            end
        end
    end

`ifdef IOB_CACHE_CTRL_IO_EN
    logic        r_ctrl_we;
    logic [3:0]  r_ctrl_addr;
    logic [DATA_W-1:0] r_ctrl_wdata;

    assign w_ctrl       = iob_addr_i[ADDR_W-1];
    assign ctrl_req_o   = r_state == CTRL_RESP;
    assign ctrl_we_o    = ctrl_req_o & r_ctrl_we;
    assign ctrl_addr_o  = r_ctrl_addr;
    assign ctrl_wdata_o = r_ctrl_wdata;
    assign w_ctrl_rd    = ctrl_req_o & ~r_ctrl_we;
    assign w_ctrl_rdata = ctrl_rdata_i;
    assign w_unused     = ^iob_addr_i[NBYTES_W-1:0];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ctrl_we    <= 1'b0;
            r_ctrl_addr  <= '0;
            r_ctrl_wdata <= '0;
        end else if (w_accept & w_ctrl) begin
            r_ctrl_we    <= |iob_wstrb_i;
            r_ctrl_addr  <= iob_addr_i[5:2];
            r_ctrl_wdata <= iob_wdata_i;
        end
    end
`else
    assign w_ctrl       = 1'b0;
    assign ctrl_req_o   = 1'b0;
    assign ctrl_we_o    = 1'b0;
    assign ctrl_addr_o  = '0;
    assign ctrl_wdata_o = '0;
    assign w_ctrl_rd    = 1'b0;
    assign w_ctrl_rdata = '0;
    assign w_unused     = ^{ctrl_rdata_i, iob_addr_i[NBYTES_W-1:0]};
`endif

endmodule

// File: tb/tb_iob_cache_front_end.sv
// tb_iob_cache_front_end: directed vector table, reset/control sequences and a
// randomized run checked against a one-outstanding-transaction reference model.
module tb_iob_cache_front_end;
    logic        clk_i = 1'b0, arst_i = 1'b1;
    logic        iob_avalid_i = 1'b0;
    logic [23:0] iob_addr_i = '0;
    logic [31:0] iob_wdata_i = '0;
    logic [3:0]  iob_wstrb_i = '0;
    logic        iob_ready_o, iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic        data_req_o;
    logic [21:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_rdata_i = '0;
    logic        data_ack_i = 1'b0;
    logic        ctrl_req_o, ctrl_we_o;
    logic [3:0]  ctrl_addr_o;
    logic [31:0] ctrl_wdata_o;
    logic [31:0] ctrl_rdata_i = '0;

    int checks = 0, errors = 0;

    iob_cache_front_end #(.ADDR_W(24), .DATA_W(32)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
        .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o), .iob_rdata_o(iob_rdata_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_wstrb_o(data_wstrb_o),
        .data_rdata_i(data_rdata_i), .data_ack_i(data_ack_i),
        .ctrl_req_o(ctrl_req_o), .ctrl_we_o(ctrl_we_o), .ctrl_addr_o(ctrl_addr_o), .ctrl_wdata_o(ctrl_wdata_o),
        .ctrl_rdata_i(ctrl_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: at most one outstanding data request; a read completes one cycle after its ack.
    logic        use_model = 1'b1;
    logic        m_busy = 1'b0, m_rv = 1'b0;
    logic [21:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wstrb = '0;

    task automatic model_reset();
        m_busy = 1'b0; m_rv = 1'b0; m_rdata = '0;
    endtask

    // Entered at posedge+1: drive inputs, check at negedge, advance the model, return at next posedge+1.
    task automatic apply(input logic av, input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic ack, input logic [31:0] rd);
        logic rdy, nrv;
        iob_avalid_i = av; iob_addr_i = a; iob_wdata_i = wd; iob_wstrb_i = ws;
        data_ack_i = ack; data_rdata_i = rd;
        @(negedge clk_i);
        rdy = !m_busy || ack;
        if (use_model) begin
            chk("m_ready", iob_ready_o, rdy);
            chk("m_req", data_req_o, m_busy);
            chk("m_rvalid", iob_rvalid_o, m_rv);
            chk("m_rdata", iob_rdata_o, m_rdata);
            if (m_busy) begin
                chk("m_addr", data_addr_o, m_addr);
                chk("m_wdata", data_wdata_o, m_wdata);
                chk("m_wstrb", data_wstrb_o, m_wstrb);
            end
        end
        nrv = 1'b0;
        if (m_busy && ack) begin
            if (m_wstrb == 4'h0) begin
                nrv = 1'b1;
                m_rdata = rd;
            end
            m_busy = 1'b0;
        end
        if (av && rdy) begin
            m_busy = 1'b1; m_addr = a[23:2]; m_wdata = wd; m_wstrb = ws;
        end
        m_rv = nrv;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic        av;
        logic [23:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        ack;
        logic [31:0] rd;
        logic        e_ready, e_req, e_rv;
        logic [31:0] e_rdata;
        logic [21:0] e_addr;
        logic [3:0]  e_wstrb;
    } vec_t;

    function automatic vec_t v(input logic av, input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               input logic ack, input logic [31:0] rd, input logic e_ready, input logic e_req,
                               input logic e_rv, input logic [31:0] e_rdata, input logic [21:0] e_addr,
                               input logic [3:0] e_wstrb);
        vec_t r;
        r.av = av; r.a = a; r.wd = wd; r.ws = ws; r.ack = ack; r.rd = rd;
        r.e_ready = e_ready; r.e_req = e_req; r.e_rv = e_rv; r.e_rdata = e_rdata; r.e_addr = e_addr; r.e_wstrb = e_wstrb;
        return r;
    endfunction

    vec_t tbl[17];

    initial begin
        tbl[0]  = v(1, 24'h10, 0, 4'h0, 0, 0,            1, 0, 0, 32'h0,        0, 0);
        tbl[1]  = v(0, 0, 0, 0, 0, 0,                    0, 1, 0, 32'h0,        22'h4, 4'h0);
        tbl[2]  = v(0, 0, 0, 0, 0, 0,                    0, 1, 0, 32'h0,        22'h4, 4'h0);
        tbl[3]  = v(0, 0, 0, 0, 1, 32'hDEADBEEF,         1, 1, 0, 32'h0,        22'h4, 4'h0);
        tbl[4]  = v(0, 0, 0, 0, 0, 0,                    1, 0, 1, 32'hDEADBEEF, 0, 0);
        tbl[5]  = v(0, 0, 0, 0, 0, 0,                    1, 0, 0, 32'hDEADBEEF, 0, 0);
        tbl[6]  = v(1, 24'h20, 32'h12345678, 4'hF, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0, 0);
        tbl[7]  = v(0, 0, 0, 0, 1, 32'h99,               1, 1, 0, 32'hDEADBEEF, 22'h8, 4'hF);
        tbl[8]  = v(0, 0, 0, 0, 0, 0,                    1, 0, 0, 32'hDEADBEEF, 0, 0);
        tbl[9]  = v(0, 0, 0, 0, 1, 32'h55,               1, 0, 0, 32'hDEADBEEF, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 0, 0,                    1, 0, 0, 32'hDEADBEEF, 0, 0);
        tbl[11] = v(1, 24'h0, 0, 4'h0, 0, 0,             1, 0, 0, 32'hDEADBEEF, 0, 0);
        tbl[12] = v(1, 24'h4, 0, 4'h0, 0, 0,             0, 1, 0, 32'hDEADBEEF, 22'h0, 4'h0);
        tbl[13] = v(1, 24'h4, 0, 4'h0, 1, 32'hAAAA0001,  1, 1, 0, 32'hDEADBEEF, 22'h0, 4'h0);
        tbl[14] = v(0, 0, 0, 0, 0, 0,                    0, 1, 1, 32'hAAAA0001, 22'h1, 4'h0);
        tbl[15] = v(0, 0, 0, 0, 1, 32'hBBBB0002,         1, 1, 0, 32'hAAAA0001, 22'h1, 4'h0);
        tbl[16] = v(0, 0, 0, 0, 0, 0,                    1, 0, 1, 32'hBBBB0002, 0, 0);

        @(negedge clk_i);
        chk("rst_rvalid", iob_rvalid_o, 0);
        chk("rst_rdata", iob_rdata_o, 0);
        chk("rst_req", data_req_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_wdata", data_wdata_o, 0);
        chk("rst_wstrb", data_wstrb_o, 0);
        chk("rst_ctrl", {ctrl_req_o, ctrl_we_o, ctrl_addr_o, ctrl_wdata_o}, 0);
        @(posedge clk_i);
        #1 arst_i = 1'b0;

        for (int i = 0; i < 17; i++) begin
            iob_avalid_i = tbl[i].av; iob_addr_i = tbl[i].a; iob_wdata_i = tbl[i].wd; iob_wstrb_i = tbl[i].ws;
            data_ack_i = tbl[i].ack; data_rdata_i = tbl[i].rd;
            @(negedge clk_i);
            chk($sformatf("v%0d_ready", i), iob_ready_o, tbl[i].e_ready);
            chk($sformatf("v%0d_req", i), data_req_o, tbl[i].e_req);
            chk($sformatf("v%0d_rvalid", i), iob_rvalid_o, tbl[i].e_rv);
            chk($sformatf("v%0d_rdata", i), iob_rdata_o, tbl[i].e_rdata);
            if (tbl[i].e_req) begin
                chk($sformatf("v%0d_addr", i), data_addr_o, tbl[i].e_addr);
                chk($sformatf("v%0d_wstrb", i), data_wstrb_o, tbl[i].e_wstrb);
            end
            @(posedge clk_i);
            #1;
        end
        m_rdata = 32'hBBBB0002;

        // reset in the middle of an outstanding read
        apply(1, 24'h40, 0, 4'h0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("pre_rst_req", data_req_o, 1);
        data_ack_i = 1'b1; data_rdata_i = 32'h1234;
        #2 arst_i = 1'b1;
        #1;
        chk("arst_req", data_req_o, 0);
        chk("arst_rvalid", iob_rvalid_o, 0);
        chk("arst_addr", data_addr_o, 0);
        @(posedge clk_i);
        #1 arst_i = 1'b0;
        model_reset();
        chk("rel_ready", iob_ready_o, 1);
        apply(0, 0, 0, 0, 1, 32'h777);
        apply(0, 0, 0, 0, 0, 0);
        chk("rel_rvalid", iob_rvalid_o, 0);

`ifdef IOB_CACHE_CTRL_IO_EN
        use_model = 1'b0;
        ctrl_rdata_i = 32'h5;
        apply(1, 24'h800008, 0, 4'h0, 0, 0);
        chk("c_req", ctrl_req_o, 1);
        chk("c_addr", ctrl_addr_o, 4'h2);
        chk("c_we", ctrl_we_o, 0);
        chk("c_ready", iob_ready_o, 0);
        chk("c_dreq", data_req_o, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("c_rvalid", iob_rvalid_o, 1);
        chk("c_rdata", iob_rdata_o, 32'h5);
        chk("c_req_end", ctrl_req_o, 0);
        chk("c_dreq2", data_req_o, 0);
        apply(1, 24'h800004, 32'h77, 4'h3, 0, 0);
        chk("cw_req", ctrl_req_o, 1);
        chk("cw_we", ctrl_we_o, 1);
        chk("cw_addr", ctrl_addr_o, 4'h1);
        chk("cw_wdata", ctrl_wdata_o, 32'h77);
        apply(0, 0, 0, 0, 0, 0);
        chk("cw_rvalid", iob_rvalid_o, 0);
        chk("cw_ready", iob_ready_o, 1);
        model_reset();
        m_rdata = 32'h5;
        use_model = 1'b1;
`else
        apply(1, 24'h800008, 0, 4'h0, 0, 0);
        chk("msb_ctrl_req", ctrl_req_o, 0);
        chk("msb_dreq", data_req_o, 1);
        chk("msb_addr", data_addr_o, 22'h200002);
        apply(0, 0, 0, 0, 1, 32'h5);
        apply(0, 0, 0, 0, 0, 0);
        chk("msb_ctrl_req2", ctrl_req_o, 0);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [23:0] a;
            logic [3:0]  ws;
            a = 24'($urandom);
`ifdef IOB_CACHE_CTRL_IO_EN
            a[23] = 1'b0;
`endif
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            apply(1'($urandom_range(0, 1)), a, $urandom, ws, 1'($urandom_range(0, 1)), $urandom);
            if (!use_model) chk("rnd_ctrl", ctrl_req_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
